// File: rtl/ethernet_pkg.sv
// Shared types and constants for the ethernet rx path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ethernet_pkg;

   typedef enum logic [1:0] {
      HDR     = 2'd0,
      BODY    = 2'd1,
      DISCARD = 2'd2
   } rx_filter_state_e;

   localparam int          eth_hdr_bytes_gp  = 14;
   localparam int          eth_dest_bytes_gp = 6;
   localparam logic [47:0] eth_bcast_mac_gp  = 48'hFFFF_FFFF_FFFF;

   // Number of valid byte lanes in a tkeep of up to 8 lanes.
   function automatic int unsigned popcount8(input logic [7:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/ethernet_rx_dest_match.sv
// Compares the destination-MAC bytes carried by one beat against the station and broadcast address.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports:
//   beat_i      beat index within the frame (0 = first beat)
//   tdata_i     beat data, byte 0 in [7:0]
//   tkeep_i     byte-lane enables of the beat
//   mac_addr_i  station MAC, [7:0] = first byte on the wire
//   ucast_o     1 if every destination byte in this beat equals the station MAC
//   bcast_o     1 if every destination byte in this beat is 8'hFF
// Beats that carry no destination bytes report a match on both outputs, so the
// caller can simply AND the per-beat results over the whole frame.
module ethernet_rx_dest_match
   import ethernet_pkg::*;
#(
   parameter int data_width_p = 32,
   parameter int beat_width_p = 9
) (
   input  logic [beat_width_p-1:0]   beat_i,
   input  logic [data_width_p-1:0]   tdata_i,
   input  logic [data_width_p/8-1:0] tkeep_i,
   input  logic [47:0]               mac_addr_i,
   output logic                      ucast_o,
   output logic                      bcast_o
);

   localparam int bytes_lp = data_width_p / 8;

   always_comb begin
      ucast_o = 1'b1;
      bcast_o = 1'b1;
      for (int k = 0; k < eth_dest_bytes_gp; k++) begin
         // Destination byte k lives in beat k/bytes_lp, lane k%bytes_lp.
         // A missing lane cannot match; such a frame is a runt anyway.
         if (int'(beat_i) == k / bytes_lp) begin
            ucast_o = ucast_o & tkeep_i[k % bytes_lp]
                    & (tdata_i[(k % bytes_lp)*8 +: 8] == mac_addr_i[k*8 +: 8]);
            bcast_o = bcast_o & tkeep_i[k % bytes_lp]
                    & (tdata_i[(k % bytes_lp)*8 +: 8] == eth_bcast_mac_gp[k*8 +: 8]);
         end
      end
   end

endmodule

// File: rtl/ethernet_sat_counter.sv
// Saturating event counter used for the rx filter statistics (built only with ETH_RX_FILTER_STATS_EN).
// Latency: count_o reflects an increment one cycle after inc_i.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset (clears to 0)
//   inc_i           count one event this cycle
//   count_o         current count
`ifdef ETH_RX_FILTER_STATS_EN
module ethernet_sat_counter #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o
);

   logic [width_p-1:0] count_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule
`endif

// File: rtl/ethernet_rx_filter.sv
// AXIS frame filter in front of ethernet_receiver: dest-MAC/runt/oversize checks, bad frames flagged by tuser on tlast.
// Latency: 1 cycle (single registered output stage), full throughput.
// Backpressure: s_axis_tready_o = ~m_axis_tvalid_o | m_axis_tready_i; output holds while stalled.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   mac_addr_i, promisc_i   station MAC ([7:0] first on wire), skip destination check
//   s_axis_*_i / _o         MAC-side stream (tuser on tlast = MAC-reported bad frame)
//   m_axis_*_o / _i         stream to ethernet_receiver
//   accept_count_o, drop_count_o  saturating frame counters, present only when
//                                 ETH_RX_FILTER_STATS_EN is defined
// Oversize frames are cut so at most eth_mtu_p/(data_width_p/8) beats reach the receiver.
module ethernet_rx_filter
   import ethernet_pkg::*;
#(
   parameter int data_width_p = 32,
   parameter int eth_mtu_p    = 2048,
   parameter int stat_width_p = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [47:0]               mac_addr_i,
   input  logic                      promisc_i,
   input  logic [data_width_p-1:0]   s_axis_tdata_i,
   input  logic [data_width_p/8-1:0] s_axis_tkeep_i,
   input  logic                      s_axis_tvalid_i,
   output logic                      s_axis_tready_o,
   input  logic                      s_axis_tlast_i,
   input  logic                      s_axis_tuser_i,
   output logic [data_width_p-1:0]   m_axis_tdata_o,
   output logic [data_width_p/8-1:0] m_axis_tkeep_o,
   output logic                      m_axis_tvalid_o,
   input  logic                      m_axis_tready_i,
   output logic                      m_axis_tlast_o,
   output logic                      m_axis_tuser_o
`ifdef ETH_RX_FILTER_STATS_EN
   ,
   output logic [stat_width_p-1:0]   accept_count_o,
   output logic [stat_width_p-1:0]   drop_count_o
`endif
);

   localparam int bytes_lp     = data_width_p / 8;
   localparam int n_beats_lp   = eth_mtu_p / bytes_lp;
   localparam int bw_lp        = $clog2(n_beats_lp);
   localparam int lw_lp        = $clog2(eth_mtu_p + 1) + 1;
   localparam int hdr_beats_lp = (eth_dest_bytes_gp + bytes_lp - 1) / bytes_lp;

   if (!((data_width_p == 32) || (data_width_p == 64)) || (stat_width_p < 1)
       || ((eth_mtu_p % bytes_lp) != 0)) begin : g_bad_cfg
      $error("ethernet_rx_filter: unsupported parameter combination");
   end

   rx_filter_state_e state_q, state_d;
   logic [bw_lp-1:0] beat_q, beat_d;
   logic             match_ucast_q, match_ucast_d;
   logic             match_bcast_q, match_bcast_d;

   logic [data_width_p-1:0]   m_data_q;
   logic [data_width_p/8-1:0] m_keep_q;
   logic                      m_valid_q, m_last_q, m_user_q;

   logic             s_rdy, acc, fwd, out_user;
   logic             lane_ucast, lane_bcast, ucast_now, bcast_now, last_bad;
   logic [lw_lp-1:0] frame_bytes;

   ethernet_rx_dest_match #(
      .data_width_p (data_width_p),
      .beat_width_p (bw_lp)
   ) u_dest_match (
      .beat_i     (beat_q),
      .tdata_i    (s_axis_tdata_i),
      .tkeep_i    (s_axis_tkeep_i),
      .mac_addr_i (mac_addr_i),
      .ucast_o    (lane_ucast),
      .bcast_o    (lane_bcast)
   );

   assign s_rdy       = ~m_valid_q | m_axis_tready_i;
   assign acc         = s_axis_tvalid_i & s_rdy;
   // Past the header beats the lane matcher returns 1, so these stay frozen in BODY.
   assign ucast_now   = match_ucast_q & lane_ucast;
   assign bcast_now   = match_bcast_q & lane_bcast;
   assign frame_bytes = lw_lp'(beat_q) * lw_lp'(bytes_lp)
                      + lw_lp'(popcount8(8'(s_axis_tkeep_i)));
   assign last_bad    = s_axis_tuser_i
                      | (frame_bytes < lw_lp'(eth_hdr_bytes_gp))
                      | ~(promisc_i | ucast_now | bcast_now);

   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      match_ucast_d = match_ucast_q;
      match_bcast_d = match_bcast_q;
      fwd           = 1'b0;
      out_user      = 1'b0;
      if (acc) begin
         if (s_axis_tlast_i) begin
            // End of frame in any state: forward it and rearm for the next frame.
            fwd           = 1'b1;
            out_user      = (state_q == DISCARD) | last_bad;
            state_d       = HDR;
            beat_d        = '0;
            match_ucast_d = 1'b1;
            match_bcast_d = 1'b1;
         end else if ((state_q == DISCARD)
                      || ((state_q == BODY) && (beat_q == bw_lp'(n_beats_lp - 1)))) begin
            // Keep the last output slot free for the tlast beat that carries the verdict.
            state_d = DISCARD;
         end else begin
            fwd           = 1'b1;
            beat_d        = beat_q + 1'b1;
            match_ucast_d = ucast_now;
            match_bcast_d = bcast_now;
            if ((state_q == HDR) && (beat_q == bw_lp'(hdr_beats_lp - 1))) begin
               state_d = BODY;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= HDR;
         beat_q        <= '0;
         match_ucast_q <= 1'b1;
         match_bcast_q <= 1'b1;
         m_valid_q     <= 1'b0;
         m_data_q      <= '0;
         m_keep_q      <= '0;
         m_last_q      <= 1'b0;
         m_user_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         match_ucast_q <= match_ucast_d;
         match_bcast_q <= match_bcast_d;
         if (s_rdy) begin
            m_valid_q <= fwd;
            if (fwd) begin
               m_data_q <= s_axis_tdata_i;
               m_keep_q <= s_axis_tkeep_i;
               m_last_q <= s_axis_tlast_i;
               m_user_q <= out_user;
            end
         end
      end
   end

   assign s_axis_tready_o = s_rdy;
   assign m_axis_tdata_o  = m_data_q;
   assign m_axis_tkeep_o  = m_keep_q;
   assign m_axis_tvalid_o = m_valid_q;
   assign m_axis_tlast_o  = m_last_q;
   assign m_axis_tuser_o  = m_user_q;

`ifdef ETH_RX_FILTER_STATS_EN
   logic ld_last;
   assign ld_last = s_rdy & fwd & s_axis_tlast_i;

   ethernet_sat_counter #(.width_p(stat_width_p)) u_accept_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (ld_last & ~out_user),
      .count_o (accept_count_o)
   );

   ethernet_sat_counter #(.width_p(stat_width_p)) u_drop_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (ld_last & out_user),
      .count_o (drop_count_o)
   );
`endif

endmodule

// File: tb/tb_ethernet_rx_filter.sv
// Directed bench for ethernet_rx_filter (32-bit data, 2048-byte MTU).
// Latency: n/a.
// Backpressure: drives m_axis_tready_i either always-high or random.
module tb_ethernet_rx_filter;

   localparam int DW  = 32;
   localparam int MTU = 2048;
   localparam int N   = MTU / (DW / 8);

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic        u;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic [47:0]   mac_addr_i = 48'h6655_4433_2211;
   logic          promisc_i = 1'b0;
   logic [DW-1:0] s_axis_tdata_i = '0;
   logic [3:0]    s_axis_tkeep_i = '0;
   logic          s_axis_tvalid_i = 1'b0;
   logic          s_axis_tready_o;
   logic          s_axis_tlast_i = 1'b0;
   logic          s_axis_tuser_i = 1'b0;
   logic [DW-1:0] m_axis_tdata_o;
   logic [3:0]    m_axis_tkeep_o;
   logic          m_axis_tvalid_o;
   logic          m_axis_tready_i = 1'b1;
   logic          m_axis_tlast_o;
   logic          m_axis_tuser_o;
`ifdef ETH_RX_FILTER_STATS_EN
   logic [15:0]   accept_count_o;
   logic [15:0]   drop_count_o;
`endif

   always #5 clk = ~clk;

   ethernet_rx_filter #(.data_width_p(DW), .eth_mtu_p(MTU), .stat_width_p(16)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .mac_addr_i      (mac_addr_i),
      .promisc_i       (promisc_i),
      .s_axis_tdata_i  (s_axis_tdata_i),
      .s_axis_tkeep_i  (s_axis_tkeep_i),
      .s_axis_tvalid_i (s_axis_tvalid_i),
      .s_axis_tready_o (s_axis_tready_o),
      .s_axis_tlast_i  (s_axis_tlast_i),
      .s_axis_tuser_i  (s_axis_tuser_i),
      .m_axis_tdata_o  (m_axis_tdata_o),
      .m_axis_tkeep_o  (m_axis_tkeep_o),
      .m_axis_tvalid_o (m_axis_tvalid_o),
      .m_axis_tready_i (m_axis_tready_i),
      .m_axis_tlast_o  (m_axis_tlast_o),
      .m_axis_tuser_o  (m_axis_tuser_o)
`ifdef ETH_RX_FILTER_STATS_EN
      ,
      .accept_count_o  (accept_count_o),
      .drop_count_o    (drop_count_o)
`endif
   );

   beat_t in_q[$];
   beat_t exp_q[$];
   int    n_vec = 0, n_err = 0;
   int    exp_acc = 0, exp_drop = 0, fid = 0;
   int    cyc = 0, in_cyc = 0, out_cyc = -100;
   bit    rnd_rdy = 0, mon_en = 0, lat_arm_in = 0, lat_arm_out = 0;
   bit    prev_stall = 0;
   beat_t held;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: compare every handshaken beat against the expected queue and
   // check that a stalled beat does not change.
   always @(negedge clk) begin
      beat_t cur;
      cyc++;
      cur = {m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o, m_axis_tuser_o};
      if (mon_en) begin
         if (prev_stall) chk("hold", 64'(cur), 64'(held));
         if (lat_arm_out && m_axis_tvalid_o) begin
            out_cyc     = cyc;
            lat_arm_out = 0;
         end
         if (m_axis_tvalid_o && m_axis_tready_i) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat_pending", 64'(exp_q.size()), 64'(1));
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat", 64'(cur), 64'(e));
            end
         end
      end
      prev_stall = m_axis_tvalid_o & ~m_axis_tready_i;
      held       = cur;
   end

   always @(posedge clk) begin
      #1;
      m_axis_tready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Queue one frame on the input and its expected output beats.
   task automatic add_frame(input logic [47:0] dest, input int len, input bit mac_bad);
      int    nb;
      bit    bad;
      beat_t b;
      nb  = (len + 3) / 4;
      bad = mac_bad || (len < 14)
            || !(promisc_i || (dest == mac_addr_i) || (dest == 48'hFFFF_FFFF_FFFF));
      for (int i = 0; i < nb; i++) begin
         b = '0;
         for (int j = 0; j < 4; j++) begin
            if (i*4 + j < len) begin
               b.k[j] = 1'b1;
               b.d[j*8 +: 8] = (i*4 + j < 6) ? dest[(i*4 + j)*8 +: 8]
                                             : 8'(fid*13 + (i*4 + j)*7 + 1);
            end
         end
         b.l = (i == nb - 1);
         b.u = b.l & mac_bad;
         in_q.push_back(b);
         if (nb <= N) begin
            b.u = b.l & bad;
            exp_q.push_back(b);
         end else if (i < N - 1) begin
            b.u = 1'b0;
            exp_q.push_back(b);
         end else if (i == nb - 1) begin
            b.u = 1'b1;
            exp_q.push_back(b);
         end
      end
      if (bad || (nb > N)) exp_drop++;
      else                 exp_acc++;
      fid++;
   endtask

   task automatic drive(input int max_beats);
      int sent, guard;
      sent  = 0;
      guard = 0;
      while ((in_q.size() > 0) && (sent < max_beats) && (guard < 20000)) begin
         @(negedge clk);
         #1;
         {s_axis_tdata_i, s_axis_tkeep_i, s_axis_tlast_i, s_axis_tuser_i} = in_q[0];
         s_axis_tvalid_i = 1'b1;
         if (s_axis_tready_o) begin
            if (lat_arm_in) begin
               in_cyc     = cyc;
               lat_arm_in = 0;
            end
            void'(in_q.pop_front());
            sent++;
         end
         guard++;
      end
      @(negedge clk);
      #1;
      s_axis_tvalid_i = 1'b0;
      if (sent < max_beats) chk("drive_left", 64'(in_q.size()), 64'(0));
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() > 0) && (g < 5000)) begin
         @(negedge clk);
         g++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'(0));
      repeat (2) @(negedge clk);
   endtask

   logic [47:0] dest_tab[6] = '{48'h6655_4433_2211, 48'hFFFF_FFFF_FFFF, 48'h0A0B_0C0D_0E0F,
                                48'h6655_4433_2212, 48'h7755_4433_2211, 48'h6655_4433_2211};
   int          len_tab[6]  = '{64, 60, 14, 97, 13, 150};

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 64'(m_axis_tvalid_o), 64'(0));
      chk("rst_tlast",  64'(m_axis_tlast_o),  64'(0));
      chk("rst_tuser",  64'(m_axis_tuser_o),  64'(0));
      chk("rst_tdata",  64'(m_axis_tdata_o),  64'(0));
      chk("rst_tkeep",  64'(m_axis_tkeep_o),  64'(0));
      chk("rst_tready", 64'(s_axis_tready_o), 64'(1));
      reset_i = 1'b0;
      mon_en  = 1;
      repeat (2) @(negedge clk);

      // 1: good unicast frame, latency 1
      lat_arm_in  = 1;
      lat_arm_out = 1;
      add_frame(mac_addr_i, 64, 0);
      drive(1 << 30);
      drain();
      chk("latency", 64'(out_cyc - in_cyc), 64'(1));

      // 2: broadcast, foreign unicast (incl. mismatch in header beat 1), promiscuous
      add_frame(48'hFFFF_FFFF_FFFF, 60, 0);
      add_frame(48'h0A0B_0C0D_0E0F, 60, 0);
      add_frame(48'h7755_4433_2211, 64, 0);
      drive(1 << 30);
      drain();
      promisc_i = 1'b1;
      add_frame(48'h0A0B_0C0D_0E0F, 60, 0);
      add_frame(mac_addr_i, 60, 1);
      drive(1 << 30);
      drain();
      promisc_i = 1'b0;

      // 3: runts around the 14-byte boundary, tlast inside the header
      add_frame(mac_addr_i, 10, 0);
      add_frame(mac_addr_i, 14, 0);
      add_frame(mac_addr_i, 13, 0);
      add_frame(mac_addr_i, 4, 0);
      drive(1 << 30);
      drain();

      // 4: MTU boundary and truncation, then a clean frame right behind
      add_frame(mac_addr_i, 2048, 0);
      add_frame(mac_addr_i, 2052, 0);
      add_frame(mac_addr_i, 64, 0);
      add_frame(mac_addr_i, 2049, 0);
      add_frame(mac_addr_i, 20, 0);
      drive(1 << 30);
      drain();
`ifdef ETH_RX_FILTER_STATS_EN
      chk("accept_count", 64'(accept_count_o), 64'(exp_acc));
      chk("drop_count",   64'(drop_count_o),   64'(exp_drop));
`endif

      // 5: random output backpressure with back-to-back frames
      rnd_rdy = 1;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 6; i++) add_frame(dest_tab[i], len_tab[i] + r*3, (i == 5) && (r == 1));
      end
      drive(1 << 30);
      drain();
      rnd_rdy = 0;
      repeat (2) @(negedge clk);

      // 6: reset in the middle of a frame
      mon_en = 0;
      add_frame(mac_addr_i, 64, 0);
      drive(5);
      reset_i = 1'b1;
      in_q.delete();
      exp_q.delete();
      @(negedge clk);
      chk("midrst_tvalid", 64'(m_axis_tvalid_o), 64'(0));
      @(negedge clk);
      chk("midrst_tvalid2", 64'(m_axis_tvalid_o), 64'(0));
      chk("midrst_tuser",   64'(m_axis_tuser_o),  64'(0));
      reset_i = 1'b0;
      @(negedge clk);
      mon_en = 1;
      add_frame(mac_addr_i, 64, 0);
      drive(1 << 30);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
